// File: rtl/fir_fold_sched.sv
// Folded FIR: one shared 16x16 MAC stepped across NUM_TAPS taps per accepted sample.
// Optional runtime coefficient write port enabled by defining FIR_COEF_WRITE_EN.
module fir_fold_sched #(
  parameter int NUM_TAPS = 170,
  parameter int AW       = $clog2(NUM_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [39:0]   out_data,
  output logic          busy
`ifdef FIR_COEF_WRITE_EN
  ,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_data,
  output logic          coef_rejected
`endif
);

  // Same coefficient table as fir_filter's fir_coefs, so results stay bit-identical.
  function automatic logic [15:0] fir_coefs(input int unsigned i);
    if (i < 4)               return 16'(i + 1);
    else if (i % 2 != 0)     return 16'(-(i * 97));
    else                     return 16'(i * 61);
  endfunction

  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);
  localparam int unsigned   NT   = NUM_TAPS;

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
  state_t state, state_n;

  logic        [15:0] smp [NUM_TAPS];
  logic      [AW-1:0] wp, rp, k;
  logic        [39:0] acc, acc_n;
  logic signed [15:0] c_rd, s_rd;
  logic signed [31:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid)   state_n = MAC;
      MAC:     if (k == LAST)  state_n = HOLD;
      HOLD:    if (out_ready)  state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

`ifdef FIR_COEF_WRITE_EN
  logic [15:0] coef [NUM_TAPS];
  logic        wr_ok;

  assign wr_ok = (state == IDLE) && (32'(coef_addr) < NT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NT; i++) coef[AW'(i)] <= fir_coefs(i);
      coef_rejected <= 1'b0;
    end else begin
      coef_rejected <= coef_we && !wr_ok;
      if (coef_we && wr_ok) coef[coef_addr] <= coef_data;
    end
  end

  assign c_rd = coef[k];
`else
  assign c_rd = fir_coefs(32'(k));
`endif

  // rp walks backwards from the newest sample, so tap k reads buf[(base-k) mod N].
  assign s_rd  = smp[rp];
  assign prod  = c_rd * s_rd;
  assign acc_n = acc + {{8{prod[31]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp      <= '{default: '0};
      wp       <= '0;
      rp       <= '0;
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          smp[wp] <= in_data;
          rp      <= wp;
          wp      <= (wp == LAST) ? '0 : wp + 1'b1;
          k       <= '0;
          acc     <= '0;
        end
        MAC: begin
          acc <= acc_n;
          k   <= (k == LAST) ? '0 : k + 1'b1;
          rp  <= (rp == '0) ? LAST : rp - 1'b1;
          if (k == LAST) out_data <= acc_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_fold_sched.sv
// Bench for fir_fold_sched: 4-tap and 170-tap instances checked against a shift-register convolution model.
module tb_fir_fold_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs   [2];
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic        bz   [2];
  logic [15:0] id   [2];
  logic [39:0] od   [2];
`ifdef FIR_COEF_WRITE_EN
  logic        we [2];
  logic        cr [2];
  logic [7:0]  ca [2];
  logic [15:0] cd [2];
`endif

  fir_fold_sched #(.NUM_TAPS(4)) u4 (
    .clk(clk), .rst(rs[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0])
`ifdef FIR_COEF_WRITE_EN
    , .coef_we(we[0]), .coef_addr(ca[0][1:0]), .coef_data(cd[0]), .coef_rejected(cr[0])
`endif
  );

  fir_fold_sched #(.NUM_TAPS(170)) u170 (
    .clk(clk), .rst(rs[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1])
`ifdef FIR_COEF_WRITE_EN
    , .coef_we(we[1]), .coef_addr(ca[1]), .coef_data(cd[1]), .coef_rejected(cr[1])
`endif
  );

  int nvec = 0;
  int nmis = 0;

  int          hist [2][170];
  int          cm   [2][170];
  logic [39:0] expq0[$], expq1[$], obs0[$], obs1[$];

  int stepv [6] = '{1, 3, 6, 10, 10, 10};
  int impv  [5] = '{32767, 65534, 98301, 131068, 0};

  function automatic int ntap(input int d);
    return (d == 0) ? 4 : 170;
  endfunction

  function automatic int ref_coef(input int i);
    if (i < 4)          return i + 1;
    else if (i % 2 != 0) return -(i * 97);
    else                return i * 61;
  endfunction

  function automatic logic [39:0] obs_at(input int d, input int i);
    if (d == 0) return (i < obs0.size()) ? obs0[i] : 40'hDE_ADBE_EF00;
    else        return (i < obs1.size()) ? obs1[i] : 40'hDE_ADBE_EF00;
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, act, act, want, want);
    end
  endtask

  // y[n] = sum c[i]*x[n-i] over a plain shift-register history
  task automatic model_push(input int d, input logic [15:0] x);
    longint a = 0;
    logic [39:0] y;
    for (int i = ntap(d) - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = int'($signed(x));
    for (int i = 0; i < ntap(d); i++) a += longint'(cm[d][i]) * longint'(hist[d][i]);
    y = a[39:0];
    if (d == 0) expq0.push_back(y); else expq1.push_back(y);
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < 170; i++) begin
      hist[d][i] = 0;
      cm[d][i]   = ref_coef(i);
    end
    if (d == 0) begin expq0.delete(); obs0.delete(); end
    else        begin expq1.delete(); obs1.delete(); end
  endtask

  task automatic send(input int d, input logic [15:0] x);
    int n = 0;
    @(negedge clk);
    iv[d] = 1'b1;
    id[d] = x;
    while (!ir[d] && n < 2000) begin @(negedge clk); n++; end
    if (!ir[d]) begin
      nvec++; nmis++;
      $display("FAIL send_timeout[%0d]: in_ready still %0d, expected 1", d, ir[d]);
    end else begin
      model_push(d, x);
    end
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic wait_ov(input int d);
    int n = 0;
    while (!ov[d] && n < 400) begin @(negedge clk); n++; end
    if (!ov[d]) begin
      nvec++; nmis++;
      $display("FAIL wait_out_valid[%0d]: out_valid still %0d, expected 1", d, ov[d]);
    end
  endtask

  task automatic recv(input int d, input int stall);
    wait_ov(d);
    repeat (stall) @(negedge clk);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    #1;
    rs[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0;
    model_clear(d);
    repeat (2) @(negedge clk);
    #1;
    rs[d] = 1'b0;
  endtask

`ifdef FIR_COEF_WRITE_EN
  task automatic wcoef(input int d, input int addr, input int data, input bit rej);
    @(negedge clk);
    we[d] = 1'b1;
    ca[d] = addr[7:0];
    cd[d] = data[15:0];
    if (!rej) cm[d][addr] = int'($signed(data[15:0]));
    @(negedge clk);
    we[d] = 1'b0;
    chk($sformatf("coef_rejected_pulse[%0d]", d), cr[d], rej);
    @(negedge clk);
    chk($sformatf("coef_rejected_clear[%0d]", d), cr[d], 0);
  endtask
`endif

  // Protocol tracking: accept / handshake events seen at the active edge.
  int cyc = 0;
  bit pend [2];
  int tacc [2];
  bit pov  [2];
  logic [39:0] held [2];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rs[d]) pend[d] = 1'b0;
      else begin
        if (iv[d] && ir[d]) begin pend[d] = 1'b1; tacc[d] = cyc; end
        if (ov[d] && ordy[d]) pend[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    for (int d = 0; d < 2; d++) begin
      if (rs[d]) pov[d] = 1'b0;
      else begin
        chk("ready_valid_excl", 40'(ir[d] && ov[d]), 0);
        chk($sformatf("in_ready[%0d]", d), ir[d], !pend[d]);
        chk($sformatf("busy[%0d]", d), bz[d], pend[d]);
        chk($sformatf("out_valid[%0d]", d), ov[d], pend[d] && (cyc - tacc[d] >= ntap(d)));
        if (ov[d] && !pov[d]) begin
          if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
            nvec++; nmis++;
            $display("FAIL unexpected_output[%0d]: got %0d, expected no result", d, od[d]);
          end else begin
            e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
            chk($sformatf("out_data[%0d]", d), od[d], e);
          end
          held[d] = od[d];
          if (d == 0) obs0.push_back(od[d]); else obs1.push_back(od[d]);
        end else if (ov[d]) begin
          chk($sformatf("out_hold[%0d]", d), od[d], held[d]);
        end
        pov[d] = ov[d];
      end
    end
  end

  initial begin
    #2_000_000;
    nmis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rs[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0; id[d] = '0;
`ifdef FIR_COEF_WRITE_EN
      we[d] = 1'b0; ca[d] = '0; cd[d] = '0;
`endif
      model_clear(d);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", ir[d], 0);
      chk("rst_out_valid", ov[d], 0);
      chk("rst_busy", bz[d], 0);
      chk("rst_out_data", od[d], 0);
`ifdef FIR_COEF_WRITE_EN
      chk("rst_coef_rejected", cr[d], 0);
`endif
    end
    repeat (2) @(negedge clk);
    #1;
    rs[0] = 1'b0; rs[1] = 1'b0;

    // 170-tap latency; first result is c[0]*x
    send(1, 16'd3);
    recv(1, 0);
    chk("lat_first_result", obs_at(1, 0), 3);

    // step response (wraps the 4-entry buffer)
`ifdef FIR_COEF_WRITE_EN
    for (int i = 0; i < 4; i++) wcoef(0, i, i + 1, 1'b0);
`endif
    for (int i = 0; i < 6; i++) begin send(0, 16'd1); recv(0, 0); end
    for (int i = 0; i < 6; i++) chk($sformatf("step[%0d]", i), obs_at(0, i), 40'(stepv[i]));

    // impulse response from a clean history
    do_reset(0);
    send(0, 16'h7FFF); recv(0, 0);
    for (int i = 0; i < 4; i++) begin send(0, 16'h0000); recv(0, 1); end
    for (int i = 0; i < 5; i++) chk($sformatf("impulse[%0d]", i), obs_at(0, i), 40'(impv[i]));

    // negative samples
    send(0, 16'h8000); recv(0, 3);
    send(0, 16'hFFFF); recv(0, 1);
    send(0, 16'h1234); recv(0, 0);

    // back-pressure with a waiting sample
    send(0, 16'h0005);
    wait_ov(0);
    fork
      send(0, 16'h0007);
      begin
        repeat (20) @(negedge clk);
        chk("bp_in_ready_low", ir[0], 0);
        chk("bp_out_valid_high", ov[0], 1);
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
      end
    join
    recv(0, 0);

    // reset during MAC at T2
    send(0, 16'h0100);
    @(posedge clk);
    #1 rs[0] = 1'b1;
    #1;
    chk("rstmac_in_ready", ir[0], 0);
    chk("rstmac_out_valid", ov[0], 0);
    chk("rstmac_busy", bz[0], 0);
    chk("rstmac_out_data", od[0], 0);
    model_clear(0);
    repeat (2) @(negedge clk);
    #1 rs[0] = 1'b0;
    send(0, 16'd1); recv(0, 0);
    chk("rstmac_next_c0", obs_at(0, 0), 1);

    // long run on 170 taps, wraps the circular buffer
    for (int i = 0; i < 172; i++) begin
      int t;
      t = (i * 7919) ^ 32'h0000_A5A5;
      send(1, t[15:0]);
      recv(1, i % 3);
    end

`ifdef FIR_COEF_WRITE_EN
    send(0, 16'd3);
    wcoef(0, 2, 100, 1'b1);
    recv(0, 0);
    wcoef(1, 200, 5, 1'b1);
    wcoef(1, 169, -1234, 1'b0);
    send(1, 16'h0042); recv(1, 0);
    send(1, 16'h8001); recv(1, 0);

    // write c[0] in the same cycle the sample is accepted
    do_reset(0);
    @(negedge clk);
    we[0] = 1'b1; ca[0] = 8'd0; cd[0] = 16'hFFFB;
    iv[0] = 1'b1; id[0] = 16'd2;
    chk("wr_accept_ready", ir[0], 1);
    cm[0][0] = -5;
    model_push(0, 16'd2);
    @(negedge clk);
    we[0] = 1'b0; iv[0] = 1'b0;
    chk("wr_accept_no_reject", cr[0], 0);
    recv(0, 0);
    chk("wr_accept_used", obs_at(0, 0), 40'hFF_FFFF_FFF6);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
